// File: rtl/piso_serializer_if.sv
// Bus bundle for the parallel-in/serial-out front end.
// The producer drives the word side, and the serializer drives the serial side.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, word_done, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding the serial pattern detectors.
// WIDTH-bit words arrive over valid/ready and leave one bit per clock.
// A word that arrives on the last bit of the previous word follows with no gap,
// so downstream detectors see one continuous bitstream.
// The bus interface must be instantiated with the same WIDTH as this module.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic               clk,
  input logic               reset_n,
  piso_serializer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             transfer;

  assign last_bit = (state == SHIFT) && (bit_cnt == LAST_CNT);

  // A new word is accepted when idle, or on the final bit of the current word.
  // A word is never accepted while reset is held.
  assign bus.din_ready = reset_n && ((state == IDLE) || last_bit);
  assign transfer      = bus.din_valid && bus.din_ready;

  // The outputs decode the registered state only, so din has no path to sout.
  assign bus.sout       = (state == SHIFT)
                          ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0])
                          : IDLE_BIT;
  assign bus.sout_valid = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.word_done  = last_bit;

  // FSM: load on transfer, shift toward the output end, and reload gaplessly on the last bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            shift_reg <= bus.din;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_CNT) begin
            if (transfer) begin
              shift_reg <= bus.din;
              bit_cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (MSB_FIRST)
              shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            else
              shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
